// File: rtl/kbd_ps2_matrix_if.sv
// Signal bundle between the PS/2 matrix emulator and its surroundings:
// PS/2 line, PPI row/column drive and sense, keymap ROM lookup and event pulses.
interface kbd_ps2_matrix_if;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [11:0] col_sel_n;
    logic [5:0]  row_sel_n;
    logic [5:0]  rows_n;
    logic [11:0] cols_n;
    logic        shift_n;
    logic [8:0]  map_code;
    logic [7:0]  map_pos;
    logic        reset_req;
    logic        frame_err;

    modport master (
        output ps2_clk, ps2_dat, col_sel_n, row_sel_n, map_pos,
        input  rows_n, cols_n, shift_n, map_code, reset_req, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat, col_sel_n, row_sel_n, map_pos,
        output rows_n, cols_n, shift_n, map_code, reset_req, frame_err
    );
endinterface

// File: rtl/kbd_ps2_matrix.sv
// PS/2 keyboard receiver that decodes scan codes into a 12x6 key matrix
// which the PPI scans through active-low column/row drive lines.
module kbd_ps2_matrix #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            clk,
    input  logic            reset,
    kbd_ps2_matrix_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_data;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_byte_vld;
    logic          r_ext, r_brk;
    logic          r_shift_n, r_reset_req, r_frame_err;
    logic [5:0]    r_matrix [0:11];

    logic          w_fall;
    logic [3:0]    w_col;
    logic [2:0]    w_row;
    logic          w_map_hit;
    logic [5:0]    w_rows;
    logic [11:0]   w_cols;

    // A level change is only taken once the new level has been seen FILTER_LEN times in a row.
    assign w_fall    = r_clk_filt & ~r_clk_sync & (r_filt_cnt == FILT_LAST);
    assign w_col     = bus.map_pos[6:3];
    assign w_row     = bus.map_pos[2:0];
    assign w_map_hit = bus.map_pos[7] & (w_col < 4'd12) & (w_row < 3'd6);

    // Two-flop synchronizers and ps2_clk glitch filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_meta <= bus.ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= bus.ps2_dat;
            r_dat_sync <= r_dat_meta;
            if (r_clk_sync != r_clk_filt) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_clk_filt <= r_clk_sync;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + FW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // Frame receiver with inactivity timeout; emits one accepted byte or one error pulse per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_data      <= 8'h00;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_byte      <= 8'h00;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_sync) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_data <= {r_dat_sync, r_data[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_par   <= r_dat_sync;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (r_dat_sync && (^{r_data, r_par})) begin
                            r_byte     <= r_data;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state != ST_IDLE) begin
                if (r_to_cnt == TO_LAST) begin
                    r_state  <= ST_IDLE;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Scan-code decoder: prefix flags, matrix updates, shift level and reset request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 12; c++) r_matrix[c] <= 6'h00;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_shift_n   <= 1'b1;
            r_reset_req <= 1'b0;
        end else begin
            r_reset_req <= 1'b0;
            if (r_byte_vld) begin
                case (r_byte)
                    8'hE0: r_ext <= 1'b1;
                    8'hF0: r_brk <= 1'b1;
                    8'hAA, 8'hFF: begin
                        for (int c = 0; c < 12; c++) r_matrix[c] <= 6'h00;
                        r_shift_n <= 1'b1;
                        r_ext     <= 1'b0;
                        r_brk     <= 1'b0;
                    end
                    default: begin
                        if (w_map_hit) r_matrix[w_col][w_row] <= ~r_brk;
                        if (!r_ext && (r_byte == 8'h12 || r_byte == 8'h59)) r_shift_n <= r_brk;
                        if (!r_ext && !r_brk && r_byte == 8'h07) r_reset_req <= 1'b1;
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Matrix sense: a driven column pulls down the rows of its pressed keys, and vice versa.
    always_comb begin
        w_rows = 6'h00;
        w_cols = 12'h000;
        for (int c = 0; c < 12; c++) begin
            w_rows    = w_rows | (r_matrix[c] & {6{~bus.col_sel_n[c]}});
            w_cols[c] = |(r_matrix[c] & ~bus.row_sel_n);
        end
    end

    assign bus.rows_n    = ~w_rows;
    assign bus.cols_n    = ~w_cols;
    assign bus.shift_n   = r_shift_n;
    assign bus.map_code  = {r_ext, r_byte};
    assign bus.reset_req = r_reset_req;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_kbd_ps2_matrix.sv
// Bench for kbd_ps2_matrix: directed scan-code scenarios plus a randomized
// byte stream compared against a key-set model of the keyboard matrix.
module tb_kbd_ps2_matrix;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int LAT_MAX     = 2 + FILTER_LEN + 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fe_rise = 0, fe_hi = 0, rr_rise = 0, rr_hi = 0;
    logic fe_prev = 1'b0, rr_prev = 1'b0;
    bit   seen175 = 1'b0;

    bit   m_key [12][6];
    bit   m_ext, m_brk, m_shift_n;
    int   m_rr = 0;
    int   m_fe = 0;

    kbd_ps2_matrix_if bus_if ();

    kbd_ps2_matrix #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // External keymap ROM: arbitrary but fixed mapping, some codes deliberately out of range.
    function automatic logic [7:0] rom_lookup(input logic [8:0] code);
        logic [7:0] b;
        b = code[7:0];
        if (code == 9'h01C) return {1'b1, 4'd3, 3'd2};
        if (code[8]) return {1'b1, b[3:0], b[6:4]};
        if (b >= 8'h01 && b <= 8'h7F) return {1'b1, b[6:3], b[2:0]};
        return 8'h00;
    endfunction

    assign bus_if.map_pos = rom_lookup(bus_if.map_code);

    always @(negedge clk) begin
        if (bus_if.frame_err) fe_hi++;
        if (bus_if.frame_err && !fe_prev) fe_rise++;
        fe_prev = bus_if.frame_err;
        if (bus_if.reset_req) rr_hi++;
        if (bus_if.reset_req && !rr_prev) rr_rise++;
        rr_prev = bus_if.reset_req;
        if (bus_if.map_code == 9'h175) seen175 = 1'b1;
    end

    task automatic model_reset();
        for (int c = 0; c < 12; c++) for (int r = 0; r < 6; r++) m_key[c][r] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_shift_n = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] p;
        int c, r;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hAA || b == 8'hFF) model_reset();
        else begin
            p = rom_lookup({m_ext, b});
            c = int'(p[6:3]);
            r = int'(p[2:0]);
            if (p[7] && c < 12 && r < 6) m_key[c][r] = !m_brk;
            if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift_n = m_brk;
            if (!m_ext && !m_brk && b == 8'h07) m_rr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    function automatic logic [5:0] exp_rows(input logic [11:0] cs_n);
        logic [5:0] v;
        v = 6'h3F;
        for (int c = 0; c < 12; c++)
            for (int r = 0; r < 6; r++)
                if (!cs_n[c] && m_key[c][r]) v[r] = 1'b0;
        return v;
    endfunction

    function automatic logic [11:0] exp_cols(input logic [5:0] rs_n);
        logic [11:0] v;
        v = 12'hFFF;
        for (int c = 0; c < 12; c++)
            for (int r = 0; r < 6; r++)
                if (!rs_n[r] && m_key[c][r]) v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = (~^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic d, input bit hold_low);
        @(negedge clk);
        bus_if.ps2_dat = d;
        repeat (10) @(negedge clk);
        bus_if.ps2_clk = 1'b0;
        if (!hold_low) begin
            repeat (20) @(negedge clk);
            bus_if.ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        send_bits(make_frame(b, bad), 11);
        repeat (3) @(negedge clk);
        if (bad) m_fe++;
        else model_byte(b);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.ps2_clk = 1'b1;
        bus_if.ps2_dat = 1'b1;
        bus_if.col_sel_n = 12'h000;
        bus_if.row_sel_n = 6'h00;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_if.shift_n !== 1'b1) begin n_fail++; $display("FAIL reset_shift_n got %b want 1", bus_if.shift_n); end
        n_checks++;
        if (bus_if.reset_req !== 1'b0 || bus_if.frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got rr=%b fe=%b want 0 0", bus_if.reset_req, bus_if.frame_err);
        end
        n_checks++;
        if (bus_if.rows_n !== 6'h3F) begin n_fail++; $display("FAIL reset_rows_n got %h want 3f", bus_if.rows_n); end
        n_checks++;
        if (bus_if.cols_n !== 12'hFFF) begin n_fail++; $display("FAIL reset_cols_n got %h want fff", bus_if.cols_n); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_make_break();
        logic [10:0] f;
        bit hit;
        bus_if.col_sel_n = 12'hFF7;
        f = make_frame(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i], 1'b0);
        ps2_bit(f[10], 1'b1);
        hit = 1'b0;
        for (int k = 0; k < LAT_MAX && !hit; k++) begin
            @(negedge clk);
            if (bus_if.rows_n === 6'h3B) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL make_latency rows_n %h want 3b within %0d clk", bus_if.rows_n, LAT_MAX); end
        repeat (20) @(negedge clk);
        bus_if.ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        model_byte(8'h1C);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        n_checks++;
        if (bus_if.rows_n !== 6'h3F) begin n_fail++; $display("FAIL break_rows_n got %h want 3f", bus_if.rows_n); end
    endtask

    task automatic test_parity_err();
        int fr, fh;
        fr = fe_rise;
        fh = fe_hi;
        send_byte(8'h1C, 1'b1);
        n_checks++;
        if (fe_rise - fr !== 1 || fe_hi - fh !== 1) begin
            n_fail++; $display("FAIL parity_frame_err got %0d pulses %0d clk want 1 1", fe_rise - fr, fe_hi - fh);
        end
        n_checks++;
        if (bus_if.rows_n !== 6'h3F) begin n_fail++; $display("FAIL parity_rows_n got %h want 3f", bus_if.rows_n); end
    endtask

    task automatic test_prefix_timeout();
        int fr;
        seen175 = 1'b0;
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        n_checks++;
        if (!seen175) begin n_fail++; $display("FAIL ext_map_code got no 175 want 175"); end
        n_checks++;
        if (bus_if.map_code[8] !== 1'b0) begin n_fail++; $display("FAIL ext_cleared got %b want 0", bus_if.map_code[8]); end
        fr = fe_rise;
        send_bits(make_frame(8'h1C, 1'b0), 7);
        repeat (TIMEOUT_CYC + TIMEOUT_CYC / 5) @(negedge clk);
        send_byte(8'h1C, 1'b0);
        n_checks++;
        if (bus_if.rows_n !== 6'h3B) begin n_fail++; $display("FAIL timeout_recover rows_n got %h want 3b", bus_if.rows_n); end
        n_checks++;
        if (fe_rise != fr) begin n_fail++; $display("FAIL timeout_frame_err got %0d want 0", fe_rise - fr); end
    endtask

    task automatic test_shift_reset_req();
        int rr, rh;
        send_byte(8'h12, 1'b0);
        n_checks++;
        if (bus_if.shift_n !== 1'b0) begin n_fail++; $display("FAIL shift_make got %b want 0", bus_if.shift_n); end
        rr = rr_rise;
        rh = rr_hi;
        send_byte(8'h07, 1'b0);
        n_checks++;
        if (rr_rise - rr !== 1 || rr_hi - rh !== 1) begin
            n_fail++; $display("FAIL reset_req_pulse got %0d pulses %0d clk want 1 1", rr_rise - rr, rr_hi - rh);
        end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        n_checks++;
        if (bus_if.shift_n !== 1'b1) begin n_fail++; $display("FAIL shift_break got %b want 1", bus_if.shift_n); end
        rr = rr_rise;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h07, 1'b0);
        n_checks++;
        if (rr_rise != rr) begin n_fail++; $display("FAIL reset_req_on_break got %0d want 0", rr_rise - rr); end
    endtask

    task automatic test_multi_key_bat();
        bus_if.row_sel_n = 6'h3B;
        send_byte(8'hAA, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h52, 1'b0);
        n_checks++;
        if (bus_if.cols_n !== 12'hBF7) begin n_fail++; $display("FAIL two_keys_cols_n got %h want bf7", bus_if.cols_n); end
        send_byte(8'h1C, 1'b0);
        n_checks++;
        if (bus_if.cols_n !== 12'hBF7) begin n_fail++; $display("FAIL typematic_cols_n got %h want bf7", bus_if.cols_n); end
        send_byte(8'hAA, 1'b0);
        n_checks++;
        if (bus_if.cols_n !== 12'hFFF) begin n_fail++; $display("FAIL bat_clear_cols_n got %h want fff", bus_if.cols_n); end
    endtask

    task automatic test_reset_mid_frame();
        int fr;
        send_bits(make_frame(8'h1C, 1'b0), 5);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        fr = fe_rise;
        bus_if.row_sel_n = 6'h3B;
        bus_if.col_sel_n = 12'hFF7;
        send_byte(8'h1C, 1'b0);
        n_checks++;
        if (bus_if.cols_n !== 12'hFF7 || bus_if.rows_n !== 6'h3B) begin
            n_fail++; $display("FAIL reset_mid_frame got cols %h rows %h want ff7 3b", bus_if.cols_n, bus_if.rows_n);
        end
        n_checks++;
        if (fe_rise != fr) begin n_fail++; $display("FAIL reset_mid_frame_err got %0d want 0", fe_rise - fr); end
    endtask

    task automatic test_random();
        int fr, rr;
        logic [7:0] b;
        bit bad;
        fr = fe_rise - m_fe;
        rr = rr_rise - m_rr;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 15))
                0:       b = 8'hE0;
                1, 2:    b = 8'hF0;
                3:       b = 8'h12;
                4:       b = 8'h59;
                5:       b = 8'h07;
                6:       b = 8'hAA;
                7:       b = 8'h1C;
                default: b = 8'($urandom_range(0, 127));
            endcase
            bad = ($urandom_range(0, 9) == 0);
            send_byte(b, bad);
            bus_if.col_sel_n = 12'($urandom);
            bus_if.row_sel_n = 6'($urandom);
            #1;
            n_checks++;
            if (bus_if.rows_n !== exp_rows(bus_if.col_sel_n)) begin
                n_fail++; $display("FAIL rand_rows_n byte %h got %h want %h", b, bus_if.rows_n, exp_rows(bus_if.col_sel_n));
            end
            n_checks++;
            if (bus_if.cols_n !== exp_cols(bus_if.row_sel_n)) begin
                n_fail++; $display("FAIL rand_cols_n byte %h got %h want %h", b, bus_if.cols_n, exp_cols(bus_if.row_sel_n));
            end
            n_checks++;
            if (bus_if.shift_n !== m_shift_n) begin
                n_fail++; $display("FAIL rand_shift_n byte %h got %b want %b", b, bus_if.shift_n, m_shift_n);
            end
        end
        n_checks++;
        if (fe_rise - fr !== m_fe || fe_hi != fe_rise) begin
            n_fail++; $display("FAIL rand_frame_err got %0d pulses want %0d", fe_rise - fr, m_fe);
        end
        n_checks++;
        if (rr_rise - rr !== m_rr || rr_hi != rr_rise) begin
            n_fail++; $display("FAIL rand_reset_req got %0d pulses want %0d", rr_rise - rr, m_rr);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_parity_err();
        test_prefix_timeout();
        test_shift_reset_req();
        test_multi_key_bat();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kbd_ps2_matrix.md
KBD_PS2_MATRIX -- requirements
Module: kbd_ps2_matrix

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal samples of ps2_clk required before a level change is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 50000: number of clk cycles without a filtered ps2_clk falling edge after which a partial frame is abandoned.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 ps2_dat  in  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 col_sel_n  in  12  column drive from PPI port A (bits 7:0) and port C (bits 3:0), active low.
REQ-008 row_sel_n  in  6  row drive from PPI port B bits 7:2, active low.
REQ-009 rows_n  out  6  row sense to PPI port B bits 7:2, active low.
REQ-010 cols_n  out  12  column sense to PPI ports A and C low, active low.
REQ-011 shift_n  out  1  shift-key level to PPI port B bit 1, active low.
REQ-012 map_code  out  9  {ext, scan byte} presented to the external keymap ROM.
REQ-013 map_pos  in  8  keymap ROM answer {valid, col[3:0], row[2:0]}, combinational from map_code.
REQ-014 reset_req  out  1  one-clk pulse on F12 make.
REQ-015 frame_err  out  1  one-clk pulse on a rejected frame.

Function
REQ-016 ps2_clk and ps2_dat shall each pass through a 2-flop synchronizer; ps2_clk shall then pass through the FILTER_LEN-sample filter.
REQ-017 Receiver shall sample ps2_dat on every filtered ps2_clk falling edge; frame = start 0, 8 data bits LSB first, odd parity, stop 1 (11 edges).
REQ-018 Receiver states: IDLE, DATA (bit count 0-7), PARITY, STOP; IDLE leaves only when the start bit samples 0, otherwise stays in IDLE.
REQ-019 Frame shall be accepted on the 11th edge only if parity of data+parity bit is odd and stop = 1; otherwise frame_err pulses 1 clk and the byte is dropped.
REQ-020 If TIMEOUT_CYC cycles elapse with receiver not in IDLE and no edge, the receiver shall return to IDLE without frame_err; counter clears on every edge.
REQ-021 Accepted byte 0xE0 shall set ext flag; 0xF0 shall set brk flag; neither updates the matrix; both flags persist until the next non-prefix byte.
REQ-022 Non-prefix byte: map_code = {ext, byte} held stable for that clk; when map_pos[7]=1, col<12 and row<6, matrix[col][row] <= ~brk; otherwise no matrix change; ext and brk clear in the same clk.
REQ-023 Byte 0x12 or 0x59 with ext=0 shall drive shift state (make -> shift_n=0, break -> shift_n=1) regardless of map_pos.
REQ-024 Byte 0x07 with ext=0, brk=0 shall pulse reset_req 1 clk; break of 0x07 does nothing.
REQ-025 Byte 0xAA (BAT) or 0xFF shall clear the whole matrix and shift state; flags cleared.
REQ-026 rows_n[r] shall be 0 when any c has col_sel_n[c]=0 and matrix[c][r]=1; else 1; combinational, no latency.
REQ-027 cols_n[c] shall be 0 when any r has row_sel_n[r]=0 and matrix[c][r]=1; else 1; combinational.
REQ-028 Total latency from 11th filtered edge to updated rows_n shall be 2 clk maximum.
REQ-029 Repeated make of a held key (typematic) shall leave matrix unchanged; break of an unpressed key shall leave it 0.

Reset
REQ-030 Reset shall clear matrix, ext, brk, bit counter, timeout counter, receiver to IDLE; shift_n=1, reset_req=0, frame_err=0, rows_n=6'h3F, cols_n=12'hFFF.
REQ-031 Reset asserted mid-frame shall discard the partial frame; first frame after release shall decode normally.

Verification
REQ-032 Frame 0x1C (parity 0) with map_pos={1,4'd3,3'd2}, col_sel_n=12'hFF7 -> within 2 clk rows_n=6'h3B; then F0 1C -> rows_n=6'h3F.
REQ-033 Frame 0x1C with parity bit 1 -> frame_err pulse 1 clk, matrix unchanged, rows_n=6'h3F.
REQ-034 E0 F0 75 sequence -> map_code=9'h175 on final byte, ext and brk both 0 afterwards; 6 data bits then 60000-clk gap -> receiver IDLE, next full frame decoded, no frame_err.
REQ-035 Make 0x12 -> shift_n=0; make 0x07 -> reset_req high exactly 1 clk; F0 12 -> shift_n=1.
REQ-036 Two keys at col 3 row 2 and col 10 row 2, row_sel_n=6'h3B -> cols_n=12'hBF7; frame 0xAA -> cols_n=12'hFFF.
REQ-037 Reset asserted after start bit + 4 data bits of 0x1C, released, full 0x1C sent -> single matrix set, no frame_err.
